// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two requesters share a single WIDTH-bit inequality comparator.
// A round-robin arbiter grants at most one requester per cycle. Each requester
// has its own one-deep response slot, so a stall on one side never blocks the
// other side.
//
// Ports
//   clock, resetn             : single clock, async active-low reset
//   reqN_valid/ready          : request handshake for requester N (ready = grant)
//   reqN_a, reqN_b, reqN_op   : operands; op=1 tests equality, op=0 tests inequality
//   rspN_valid/ready/result   : held response for requester N
//   mismatch_cnt              : saturating count of granted requests with a != b
//   last_grant                : index of the most recently granted requester

// One-deep response holding register for a single requester.
module cmp_arbiter_slot (
    input  logic clock,
    input  logic resetn,
    input  logic grant,
    input  logic result_in,
    input  logic rsp_ready,
    output logic rsp_valid,
    output logic rsp_result
);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsp_valid  <= 1'b0;
            rsp_result <= 1'b0;
        end else if (grant) begin
            // A grant can coincide with the consume of the old result.
            // The new result replaces it with no bubble.
            rsp_valid  <= 1'b1;
            rsp_result <= result_in;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end
endmodule

module cmp_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_op,
    input  logic             req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic             rsp0_result,
    output logic             rsp1_result,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             last_grant
);
    localparam int NUM_REQ = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REQ-1:0] req_valid, rsp_valid, rsp_ready, rsp_result;
    logic [NUM_REQ-1:0] eligible, grant;
    logic [WIDTH-1:0]   mux_a, mux_b;
    logic               mux_op, neq, cmp_result, any_grant;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A requester may be granted only if its slot is empty or drains this cycle.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    // Round-robin between the two requesters. A requester wins when it is the
    // only eligible one, or when it was not the last one granted. Grants are
    // gated by resetn so that ready stays low while reset is held.
    assign grant[0] = resetn & eligible[0] & (~eligible[1] | last_grant);
    assign grant[1] = resetn & eligible[1] & (~eligible[0] | ~last_grant);
    assign any_grant = |grant;

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // The shared comparator. Its inputs are steered by the grant.
    assign mux_a      = grant[1] ? req1_a  : req0_a;
    assign mux_b      = grant[1] ? req1_b  : req0_b;
    assign mux_op     = grant[1] ? req1_op : req0_op;
    assign neq        = (mux_a != mux_b);
    assign cmp_result = neq ^ mux_op;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        cmp_arbiter_slot u_slot (
            .clock      (clock),
            .resetn     (resetn),
            .grant      (grant[i]),
            .result_in  (cmp_result),
            .rsp_ready  (rsp_ready[i]),
            .rsp_valid  (rsp_valid[i]),
            .rsp_result (rsp_result[i])
        );
    end

    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result[0];
    assign rsp1_result = rsp_result[1];

    // last_grant resets to 1 so the first contested cycle favours requester 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (any_grant) begin
            last_grant <= grant[1];
        end
    end

    // The counter counts operand inequality, regardless of op. It saturates.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mismatch_cnt <= '0;
        end else if (any_grant && neq && (mismatch_cnt != CNT_MAX)) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid, rsp0_result, rsp1_result;
    logic             rsp0_ready, rsp1_ready;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             last_grant;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: expected results per requester, in grant order.
    logic q0[$];
    logic q1[$];
    int   exp_cnt;
    logic exp_lg;

    cmp_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .mismatch_cnt(mismatch_cnt), .last_grant(last_grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a result leaves the DUT when valid && ready at the edge.
    always @(negedge clock) begin
        if (resetn) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chk("rsp0 unexpected", 32'd1, 32'd0);
                else chk("rsp0_result", {31'd0, rsp0_result}, {31'd0, q0.pop_front()});
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chk("rsp1 unexpected", 32'd1, 32'd0);
                else chk("rsp1_result", {31'd0, rsp1_result}, {31'd0, q1.pop_front()});
            end
        end
    end

    // Drive one cycle of stimulus. The expected grants are hand-computed.
    // On a grant, push the expected result and update the counter model.
    task automatic cyc(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic op0, input logic rr0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic op1, input logic rr1,
        input logic eg0, input logic eg1, input string tag);
        @(posedge clock); #1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; rsp0_ready = rr0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; rsp1_ready = rr1;
        @(negedge clock);
        chk({tag, " req0_ready"}, {31'd0, req0_ready}, {31'd0, eg0});
        chk({tag, " req1_ready"}, {31'd0, req1_ready}, {31'd0, eg1});
        chk({tag, " last_grant"}, {31'd0, last_grant}, {31'd0, exp_lg});
        chk({tag, " mismatch_cnt"}, {28'd0, mismatch_cnt}, exp_cnt);
        if (eg0) begin
            q0.push_back((a0 != b0) ^ op0);
            if (a0 != b0 && exp_cnt < 15) exp_cnt++;
            exp_lg = 1'b0;
        end
        if (eg1) begin
            q1.push_back((a1 != b1) ^ op1);
            if (a1 != b1 && exp_cnt < 15) exp_cnt++;
            exp_lg = 1'b1;
        end
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, tag);
    endtask

    initial begin
        resetn = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = 1'b0; req1_op = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_cnt = 0; exp_lg = 1'b1;

        // Reset state, with both requests asserted.
        repeat (2) @(negedge clock);
        chk("rst req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst last_grant", {31'd0, last_grant}, 32'd1);
        chk("rst mismatch_cnt", {28'd0, mismatch_cnt}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        resetn = 1'b1;

        // Contention: grants alternate 0,1,0,1, with 0 granted first after reset.
        cyc(1, 1, 2, 0, 1, 1, 5, 5, 0, 1, 1, 0, "cont0");
        cyc(1, 1, 2, 0, 1, 1, 5, 5, 0, 1, 0, 1, "cont1");
        cyc(1, 1, 2, 0, 1, 1, 5, 5, 0, 1, 1, 0, "cont2");
        cyc(1, 1, 2, 0, 1, 1, 5, 5, 0, 1, 0, 1, "cont3");

        // Solo equal test.
        cyc(1, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 0, 0, 0, 1, 1, 0, "solo");
        chk("solo rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        idle("solo_next");

        // Backpressure on rsp1: req0 keeps being granted while rsp1 holds.
        cyc(0, 0, 0, 0, 1, 1, 3, 4, 1, 1, 0, 1, "bp_load");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 9, 9, 0, 1, 1, 6, 6, 1, 0, 1, 0, "bp_stall");
            chk("bp rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("bp rsp1_result", {31'd0, rsp1_result}, 32'd0);
        end
        cyc(1, 9, 9, 0, 1, 1, 6, 6, 1, 1, 0, 1, "bp_release");
        idle("bp_drain");

        // Back-to-back grants to req0 while its slot drains in the same cycle.
        cyc(1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, "b2b0");
        cyc(1, 2, 3, 0, 1, 0, 0, 0, 0, 1, 1, 0, "b2b1");
        chk("b2b rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        idle("b2b_next");
        chk("b2b_next rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        idle("b2b_drain");

        // Saturation: 20 mismatching grants, with a 4-bit counter.
        for (int i = 0; i < 20; i++)
            cyc(1, 32'h0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0, 1, 1, 0, "sat");
        idle("sat_hold0");
        idle("sat_hold1");
        chk("sat final cnt", {28'd0, mismatch_cnt}, 32'd15);

        // Async reset, taken mid-cycle, while rsp0 holds an unconsumed result.
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, "ar_load");
        @(posedge clock); #1;
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        chk("ar pre rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("ar rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("ar rsp0_result", {31'd0, rsp0_result}, 32'd0);
        chk("ar mismatch_cnt", {28'd0, mismatch_cnt}, 32'd0);
        chk("ar last_grant", {31'd0, last_grant}, 32'd1);
        q0.delete(); q1.delete();
        exp_cnt = 0; exp_lg = 1'b1;
        @(negedge clock); #2 resetn = 1'b1;

        // After reset, no stale response appears, and the first contest goes to 0.
        idle("post_rst");
        chk("post_rst rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        cyc(1, 4, 4, 1, 1, 1, 4, 5, 0, 1, 1, 0, "post_cont0");
        cyc(1, 4, 4, 1, 1, 1, 4, 5, 0, 1, 0, 1, "post_cont1");
        idle("fin0");
        idle("fin1");
        chk("q0 drained", q0.size(), 32'd0);
        chk("q1 drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the mismatch counter.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester i presents a compare request.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  request of requester i accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands of requester i.
REQ-008 SHALL have ports req0_op/req1_op  input  1  0 = not-equal test, 1 = equal test.
REQ-009 SHALL have ports rsp0_valid/rsp1_valid  output  1  result for requester i is held.
REQ-010 SHALL have ports rsp0_result/rsp1_result  output  1  compare result for requester i.
REQ-011 SHALL have ports rsp0_ready/rsp1_ready  input  1  requester i consumes its result.
REQ-012 SHALL have port mismatch_cnt  output  CNT_W  number of accepted requests whose operands differed.
REQ-013 SHALL have port last_grant  output  1  index of the most recently granted requester.

Function
REQ-014 SHALL contain exactly one WIDTH-bit inequality comparator, shared by both requesters.
REQ-015 SHALL define eligible_i = reqi_valid AND (NOT rspi_valid OR rspi_ready).
REQ-016 SHALL grant at most one requester per cycle; reqi_ready = grant_i, combinational from the current-cycle inputs and state.
REQ-017 Only one requester eligible: SHALL grant that requester.
REQ-018 Both eligible: SHALL grant the requester NOT equal to last_grant (round-robin).
REQ-019 SHALL steer the granted requester's a/b/op into the shared comparator through a 2:1 mux.
REQ-020 On reqi_valid AND reqi_ready at edge N: rspi_result SHALL load (a!=b) XOR op, and rspi_valid SHALL be 1 after edge N (latency 1 cycle).
REQ-021 rspi_valid AND rspi_ready without a new grant to i: rspi_valid SHALL clear at that edge.
REQ-022 Consume and new grant to the same requester in one cycle: the new result SHALL load and rspi_valid SHALL stay 1 (no bubble).
REQ-023 rspi_valid=1 with rspi_ready=0: rspi_result SHALL hold, and reqi_ready SHALL be 0.
REQ-024 last_grant SHALL update to the granted index on every grant and hold otherwise.
REQ-025 mismatch_cnt SHALL increment by 1 on each grant whose operands differ, independent of op.
REQ-026 mismatch_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 A requester SHALL keep a/b/op stable while valid=1 and ready=0; the block does not latch them before grant.
REQ-028 rsp0 and rsp1 paths SHALL be independent; a stall on one SHALL NOT block grants to the other.

Reset
REQ-029 resetn=0 SHALL immediately, without a clock, force rsp0_valid=rsp1_valid=0, rsp0_result=rsp1_result=0, mismatch_cnt=0, last_grant=1.
REQ-030 While resetn=0, req0_ready=req1_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard held, unconsumed results; no response is produced for them after reset.
REQ-032 After reset, the first contested cycle SHALL grant requester 0 (because last_grant=1).
REQ-033 Deassertion of resetn SHALL take effect at the next rising clock edge.

Verification
REQ-034 Solo: req0 a=0x1234_5678, b=0x1234_5678, op=1, rsp0_ready=1 -> req0_ready=1; next cycle rsp0_valid=1, rsp0_result=1; mismatch_cnt=0.
REQ-035 Contention: both valid every cycle after reset, rsp ready=1 -> grants alternate 0,1,0,1; last_grant toggles each cycle.
REQ-036 Backpressure: rsp1_ready=0 with rsp1 held -> req1_ready=0, rsp1_result stable, req0 granted every cycle.
REQ-037 Saturation: CNT_W=4, 20 accepted requests with a=0, b=0xFFFF_FFFF -> mismatch_cnt reaches 15 and holds.
REQ-038 Back-to-back: req0 valid with rsp0_valid=1 and rsp0_ready=1 -> grant the same cycle, rsp0_valid stays 1, new result shown.
REQ-039 Async reset: resetn pulsed low between clock edges while rsp0_valid=1 -> rsp0_valid=0 and mismatch_cnt=0 immediately, before the next edge.
